// File: rtl/mac_pkg.sv
// Shared constants for the MAC processing element: operand and accumulator
// width defaults, and the full-precision product width derived from them.
package mac_pkg;

   localparam int DEF_BIT_WIDTH  = 8;
   localparam int DEF_ACCUM_BITS = 32;

   // Width of an exact unsigned w x w product.
   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

   localparam int PROD_BITS = prod_width(DEF_BIT_WIDTH);

endpackage : mac_pkg

// File: rtl/mac_mult.sv
// Combinational unsigned BIT_WIDTH x BIT_WIDTH multiplier.
// Partial products are formed by shift-and-AND, folded into a sum/carry
// pair with 3:2 carry-save adders, then resolved by a single ripple add.
// All arithmetic is modulo 2^(2*BIT_WIDTH), which is exact because the true
// product always fits in that width.
module mac_mult
   import mac_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
   input  logic [BIT_WIDTH-1:0]               mcand,
   input  logic [BIT_WIDTH-1:0]               mplier,
   output logic [prod_width(BIT_WIDTH)-1:0]   prod
);

   localparam int P = prod_width(BIT_WIDTH);

   logic [P-1:0] cs_sum;
   logic [P-1:0] cs_carry;

   // Carry-save reduction of the partial-product array into sum/carry vectors.
   always_comb begin
      logic [P-1:0] s;
      logic [P-1:0] c;
      logic [P-1:0] pp;
      s  = '0;
      c  = '0;
      pp = '0;
      for (int i = 0; i < BIT_WIDTH; i++) begin
         pp = {{BIT_WIDTH{1'b0}}, (mcand & {BIT_WIDTH{mplier[i]}})} << i;
         // Carry is computed from the old s/c before s is overwritten.
         c_next_calc: begin
            logic [P-1:0] maj;
            maj = (s & c) | (s & pp) | (c & pp);
            s   = s ^ c ^ pp;
            c   = maj << 1;
         end
      end
      cs_sum   = s;
      cs_carry = c;
   end

   // Final ripple-carry add of the sum and carry vectors; carry-out is always zero.
   always_comb begin
      logic carry;
      carry = 1'b0;
      prod  = '0;
      for (int j = 0; j < P; j++) begin
         prod[j] = cs_sum[j] ^ cs_carry[j] ^ carry;
         carry   = (cs_sum[j] & cs_carry[j]) | (cs_sum[j] & carry) | (cs_carry[j] & carry);
      end
   end

endmodule : mac_mult

// File: rtl/mac_pe.sv
// Single multiply-accumulate processing element:
//   partial_sum_out <= partial_sum_in + weight * inp   (unsigned, wraps)
// One cycle of latency; the only state is the output register and out_valid.
//
// Valid semantics: in_valid qualifies weight/inp/partial_sum_in at a rising
// edge. A qualified edge loads a new sum and raises out_valid for exactly the
// following cycle. An unqualified edge holds the sum and drops out_valid.
// There is no ready/backpressure; one result per cycle may stream through.
module mac_pe
   import mac_pkg::*;
#(
   parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
   parameter int ACCUM_BITS = DEF_ACCUM_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [BIT_WIDTH-1:0]  weight,
   input  logic [BIT_WIDTH-1:0]  inp,
   input  logic [ACCUM_BITS-1:0] partial_sum_in,
   output logic [ACCUM_BITS-1:0] partial_sum_out,
   output logic                  out_valid
);

   localparam int PB = prod_width(BIT_WIDTH);

   logic [PB-1:0]         prod;
   logic [ACCUM_BITS-1:0] prod_ext;
   logic [ACCUM_BITS-1:0] sum;
   logic [ACCUM_BITS-1:0] psum_d, psum_q;
   logic                  out_valid_d, out_valid_q;

   mac_mult #(
      .BIT_WIDTH (BIT_WIDTH)
   ) u_mult (
      .mcand  (weight),
      .mplier (inp),
      .prod   (prod)
   );

   // Zero-extend the exact product and add; carry-out is discarded (mod 2^ACCUM_BITS).
   always_comb begin
      prod_ext = ACCUM_BITS'(prod);
      sum      = partial_sum_in + prod_ext;
   end

   // Next-state: load on in_valid, otherwise hold the sum and drop out_valid.
   always_comb begin
      psum_d      = psum_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         psum_d      = sum;
         out_valid_d = 1'b1;
      end
   end

   // Output register with asynchronous clear; a reset discards any in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psum_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         psum_q      <= psum_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign partial_sum_out = psum_q;
   assign out_valid       = out_valid_q;

endmodule : mac_pe

// File: tb/tb_mac_pe.sv
// Self-checking bench for mac_pe (BIT_WIDTH=8, ACCUM_BITS=32).
module tb_mac_pe;

   localparam int W = 8;
   localparam int A = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [W-1:0]  weight;
   logic [W-1:0]  inp;
   logic [A-1:0]  partial_sum_in;
   logic [A-1:0]  partial_sum_out;
   logic          out_valid;

   mac_pe #(
      .BIT_WIDTH  (W),
      .ACCUM_BITS (A)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .weight          (weight),
      .inp             (inp),
      .partial_sum_in  (partial_sum_in),
      .partial_sum_out (partial_sum_out),
      .out_valid       (out_valid)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [A-1:0] exp_q[$];
   logic [A-1:0] last_sum;
   int           n_cmp;
   int           n_err;

   typedef struct {
      logic [W-1:0] w;
      logic [W-1:0] x;
      logic [A-1:0] p;
      logic [A-1:0] e;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [A-1:0] act, input logic [A-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Compare the DUT output against the scoreboard after an edge.
   task automatic check_output(input string name);
      logic [A-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({name, ".valid"}, A'(out_valid), A'(1'b1));
         check({name, ".sum"}, partial_sum_out, e);
         last_sum = e;
      end else begin
         check({name, ".valid"}, A'(out_valid), A'(1'b0));
         check({name, ".hold"}, partial_sum_out, last_sum);
      end
   endtask

   // ---------------- driver ----------------
   // Drive one cycle of inputs at the falling edge, push the expected result
   // when valid, then check just after the next rising edge.
   task automatic drive(input string name, input logic v, input logic [W-1:0] w,
                        input logic [W-1:0] x, input logic [A-1:0] p, input logic [A-1:0] e);
      @(negedge clk);
      in_valid       = v;
      weight         = w;
      inp            = x;
      partial_sum_in = p;
      if (v) exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_output(name);
   endtask

   function automatic logic [A-1:0] model(input logic [W-1:0] w, input logic [W-1:0] x,
                                          input logic [A-1:0] p);
      logic [A-1:0] pr;
      pr = A'(w) * A'(x);
      return p + pr;
   endfunction

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      last_sum = '0;
      rst_n          = 1'b0;
      in_valid       = 1'b0;
      weight         = '0;
      inp            = '0;
      partial_sum_in = '0;

      // Directed vectors with hand-derived expectations.
      vecs[0] = '{w: 8'd3,   x: 8'd5,   p: 32'd10,         e: 32'd25};
      vecs[1] = '{w: 8'd255, x: 8'd255, p: 32'd0,          e: 32'h0000FE01};
      vecs[2] = '{w: 8'd0,   x: 8'd200, p: 32'h12345678,   e: 32'h12345678};
      vecs[3] = '{w: 8'd255, x: 8'd255, p: 32'hFFFFFFFF,   e: 32'h0000FE00};
      vecs[4] = '{w: 8'd1,   x: 8'd1,   p: 32'd0,          e: 32'd1};
      vecs[5] = '{w: 8'd2,   x: 8'd2,   p: 32'd1,          e: 32'd5};
      vecs[6] = '{w: 8'd3,   x: 8'd3,   p: 32'd2,          e: 32'd11};
      vecs[7] = '{w: 8'd4,   x: 8'd4,   p: 32'd3,          e: 32'd19};
      vecs[8] = '{w: 8'd128, x: 8'd2,   p: 32'hFFFFFF00,   e: 32'h00000000};

      // Reset held low with random, valid-qualified inputs: output stays cleared.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid       = 1'b1;
         weight         = W'($urandom_range(0, 255));
         inp            = W'($urandom_range(0, 255));
         partial_sum_in = $urandom;
         @(posedge clk);
         #1;
         check("reset.valid", A'(out_valid), A'(1'b0));
         check("reset.sum", partial_sum_out, '0);
      end

      // Release at a falling edge; the next rising edge may capture.
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Table: 4 single-shot vectors, then 4 back-to-back stream, then a wrap to 0.
      for (int k = 0; k < 4; k++) begin
         drive($sformatf("vec%0d", k), 1'b1, vecs[k].w, vecs[k].x, vecs[k].p, vecs[k].e);
         drive($sformatf("vec%0d.idle", k), 1'b0, 8'hAA, 8'h55, 32'hDEADBEEF, '0);
      end
      for (int k = 4; k < 8; k++)
         drive($sformatf("stream%0d", k - 4), 1'b1, vecs[k].w, vecs[k].x, vecs[k].p, vecs[k].e);
      drive("stream.hold0", 1'b0, 8'd9, 8'd9, 32'd100, '0);
      drive("stream.hold1", 1'b0, 8'd7, 8'd6, 32'd5, '0);
      drive("wrap0", 1'b1, vecs[8].w, vecs[8].x, vecs[8].p, vecs[8].e);

      // Async reset mid-cycle with a valid operand set in flight.
      drive("pre_rst", 1'b1, 8'd10, 8'd10, 32'd7, 32'd107);
      @(negedge clk);
      in_valid       = 1'b1;
      weight         = 8'd50;
      inp            = 8'd50;
      partial_sum_in = 32'd1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst.valid", A'(out_valid), A'(1'b0));
      check("async_rst.sum", partial_sum_out, '0);
      @(posedge clk);
      #1;
      check("rst_hold.valid", A'(out_valid), A'(1'b0));
      check("rst_hold.sum", partial_sum_out, '0);
      exp_q.delete();
      last_sum = '0;
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      drive("post_rst.idle", 1'b0, 8'd50, 8'd50, 32'd1, '0);
      drive("post_rst.first", 1'b1, 8'd12, 8'd11, 32'd0, 32'd132);

      // Random stream with mixed valid/idle cycles against the behavioural model.
      for (int k = 0; k < 2000; k++) begin
         logic          v;
         logic [W-1:0]  w;
         logic [W-1:0]  x;
         logic [A-1:0]  p;
         v = ($urandom_range(0, 3) != 0);
         w = W'($urandom_range(0, 255));
         x = W'($urandom_range(0, 255));
         p = (k % 8 == 0) ? 32'hFFFFFFFF - A'($urandom_range(0, 70000)) : $urandom;
         drive("rand", v, w, x, p, model(w, x, p));
      end

      drive("final.idle", 1'b0, '0, '0, '0, '0);
      check("scoreboard.empty", A'(exp_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mac_pe
